lcd_write_arbiter: RTL and testbench

- Sequences character writes into the LCD character driver: it waits for driver init, shares it between two byte requesters, and drives its write-enable/data handshake.
- Round-robin arbitration between requesters, with packet locking so a multi-byte string from one requester is never interleaved with the other.
- Watchdog flags a driver that stops handshaking.
- Sits between display clients (status text, debug console) and the LCD driver.

---
 rtl/lcd_write_arbiter_if.sv | 49 ++++
 rtl/lcd_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_lcd_write_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_write_arbiter_if.sv
// lcd_write_arbiter_if
//   Bundles the requester handshakes, the LCD driver handshake and the
//   status outputs of lcd_write_arbiter. Clock and Reset are not part of
//   the bundle.
//
//   Signals (as seen by the arbiter, modport slave):
//     iReq0_Valid/iReq0_Data/iReq0_Last  requester 0 byte stream (in)
//     oReq0_Ready                        requester 0 byte accepted (out)
//     iReq1_*, oReq1_Ready               same for requester 1
//     iLCD_Ready, iLCD_Initialized       driver status flags (in)
//     oLCD_WriteEnable, oLCD_Data        one-cycle write request (out)
//     oOwner, oBusy, oError, oByteCount  arbiter status (out)
//   modport master is the mirror image used by clients and driver models.
interface lcd_write_arbiter_if;
  logic        iReq0_Valid;
  logic [7:0]  iReq0_Data;
  logic        iReq0_Last;
  logic        oReq0_Ready;
  logic        iReq1_Valid;
  logic [7:0]  iReq1_Data;
  logic        iReq1_Last;
  logic        oReq1_Ready;
  logic        iLCD_Ready;
  logic        iLCD_Initialized;
  logic        oLCD_WriteEnable;
  logic [7:0]  oLCD_Data;
  logic        oOwner;
  logic        oBusy;
  logic        oError;
  logic [15:0] oByteCount;

  modport slave (
    input  iReq0_Valid, iReq0_Data, iReq0_Last,
    input  iReq1_Valid, iReq1_Data, iReq1_Last,
    input  iLCD_Ready, iLCD_Initialized,
    output oReq0_Ready, oReq1_Ready,
    output oLCD_WriteEnable, oLCD_Data,
    output oOwner, oBusy, oError, oByteCount
  );

  modport master (
    output iReq0_Valid, iReq0_Data, iReq0_Last,
    output iReq1_Valid, iReq1_Data, iReq1_Last,
    output iLCD_Ready, iLCD_Initialized,
    input  oReq0_Ready, oReq1_Ready,
    input  oLCD_WriteEnable, oLCD_Data,
    input  oOwner, oBusy, oError, oByteCount
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter
//   Shares one LCD character driver between two byte requesters. Waits for
//   driver init, arbitrates round-robin with packet locking (a packet from
//   one requester is never interleaved with the other), issues a one-cycle
//   write strobe and follows the driver's ready handshake. A watchdog sets
//   a sticky error flag when the driver stops handshaking.
//
//   Ports:
//     Clock  system clock
//     Reset  synchronous reset, active-high
//     Bus    lcd_write_arbiter_if.slave (requesters, driver, status)
//
//   Parameters:
//     TIMEOUT_CYCLES  max cycles waiting for the driver to finish a write
//     BUSY_TIMEOUT    max cycles waiting for the driver to go busy
//     PRIO_INIT       requester holding priority after reset
module lcd_write_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned BUSY_TIMEOUT   = 3,
  parameter bit          PRIO_INIT      = 1'b0
) (
  input logic                Clock,
  input logic                Reset,
  lcd_write_arbiter_if.slave Bus
);

  // At least 13 bits, wider only if the done timeout needs it.
  localparam int unsigned TimerWidth =
    (TIMEOUT_CYCLES > 8191) ? $clog2(TIMEOUT_CYCLES + 1) : 13;
  localparam logic [TimerWidth-1:0] DoneLimit = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerWidth-1:0] BusyLimit = TimerWidth'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    ARB,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic [TimerWidth-1:0] timer;

  logic [7:0]  dataReg;
  logic        ownerReg;
  logic        lastReg;     // byte in flight ends its packet
  logic        lockReg;
  logic        lockOwner;
  logic        prioReg;
  logic        errorReg;
  logic [15:0] byteCount;

  logic       sel0;
  logic       sel1;
  logic       grantValid;
  logic       grantIdx;
  logic [7:0] grantData;
  logic       grantLast;
  logic       accept;
  logic       busyExpire;
  logic       doneOk;
  logic       doneExpire;

  // ---------------------------------------------------------------------
  // Requester selection
  // ---------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (lockReg) begin
      // Mid-packet: only the lock owner may continue, even if it stalls.
      sel0 = Bus.iReq0_Valid && !lockOwner;
      sel1 = Bus.iReq1_Valid &&  lockOwner;
    end else begin
      sel0 = Bus.iReq0_Valid && (!Bus.iReq1_Valid || !prioReg);
      sel1 = Bus.iReq1_Valid && (!Bus.iReq0_Valid ||  prioReg);
    end
  end

  assign grantValid = sel0 || sel1;
  assign grantIdx   = sel1;
  assign grantData  = sel1 ? Bus.iReq1_Data : Bus.iReq0_Data;
  assign grantLast  = sel1 ? Bus.iReq1_Last : Bus.iReq0_Last;

  assign accept     = (state == ARB) && grantValid;
  assign busyExpire = (state == WAIT_BUSY) && Bus.iLCD_Ready && (timer == BusyLimit);
  assign doneOk     = (state == WAIT_DONE) && Bus.iLCD_Ready;
  assign doneExpire = (state == WAIT_DONE) && !Bus.iLCD_Ready && (timer == DoneLimit);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= WAIT_INIT;
      timer <= '0;
    end else begin
      state <= stateNext;
      // Timer restarts on every state entry.
      timer <= (stateNext != state) ? '0 : timer + TimerWidth'(1);
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    unique case (state)
      WAIT_INIT: if (Bus.iLCD_Initialized && Bus.iLCD_Ready) stateNext = ARB;
      ARB:       if (grantValid) stateNext = ISSUE;
      // Initialized is rechecked so nothing is issued to an uninitialised driver.
      ISSUE:     if (Bus.iLCD_Ready && Bus.iLCD_Initialized) stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!Bus.iLCD_Ready)  stateNext = WAIT_DONE;
        else if (busyExpire)  stateNext = ARB;
      end
      WAIT_DONE: begin
        if (doneOk)           stateNext = ARB;
        else if (doneExpire)  stateNext = WAIT_INIT;
      end
      default:                stateNext = WAIT_INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    Bus.oReq0_Ready      = 1'b0;
    Bus.oReq1_Ready      = 1'b0;
    Bus.oLCD_WriteEnable = 1'b0;
    Bus.oBusy            = 1'b1;
    unique case (state)
      WAIT_INIT: Bus.oBusy = 1'b0;
      ARB: begin
        Bus.oBusy       = 1'b0;
        Bus.oReq0_Ready = sel0;
        Bus.oReq1_Ready = sel1;
      end
      ISSUE:     Bus.oLCD_WriteEnable = Bus.iLCD_Ready && Bus.iLCD_Initialized;
      default:   Bus.oBusy = 1'b1;
    endcase
  end

  assign Bus.oLCD_Data  = dataReg;
  assign Bus.oOwner     = ownerReg;
  assign Bus.oError     = errorReg;
  assign Bus.oByteCount = byteCount;

  // ---------------------------------------------------------------------
  // Datapath: holding register, lock, priority, error, byte counter
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dataReg   <= '0;
      ownerReg  <= 1'b0;
      lastReg   <= 1'b0;
      lockReg   <= 1'b0;
      lockOwner <= 1'b0;
      prioReg   <= PRIO_INIT;
      errorReg  <= 1'b0;
      byteCount <= '0;
    end else begin
      if (accept) begin
        dataReg   <= grantData;
        ownerReg  <= grantIdx;
        lastReg   <= grantLast;
        lockReg   <= !grantLast;
        lockOwner <= grantIdx;
      end
      // A watchdog drops the byte in flight and abandons its packet.
      if (busyExpire || doneExpire) begin
        errorReg <= 1'b1;
        lockReg  <= 1'b0;
      end
      if (doneOk) begin
        byteCount <= byteCount + 16'd1;
        // Round-robin hand-over happens only at packet boundaries.
        if (!lockReg && lastReg) prioReg <= !ownerReg;
      end
    end
  end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter
//   Self-checking bench for lcd_write_arbiter. Requester feeders present
//   byte queues on the handshake, a behavioural driver model answers write
//   strobes and logs every issued byte. Expected byte order comes from a
//   packet-level round-robin model.
module tb_lcd_write_arbiter;

  localparam int TIMEOUT = 64;
  localparam int DRV_NORMAL = 0;
  localparam int DRV_IGNORE = 1;
  localparam int DRV_HANG   = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  lcd_write_arbiter_if Bus ();

  lcd_write_arbiter #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .BUSY_TIMEOUT  (3),
    .PRIO_INIT     (1'b0)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Bus  (Bus)
  );

  // {last, data} per requester; {owner, data} per issued write
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] obsQ[$];
  int         wePulses = 0;
  int         drvMode  = DRV_NORMAL;
  int         nChecks  = 0;
  int         nPass    = 0;
  int         nFail    = 0;
  logic       fire0;
  logic       fire1;
  int         busyLen;

  // Requester 0 feeder
  initial begin
    Bus.iReq0_Valid = 1'b0;
    Bus.iReq0_Data  = 8'h00;
    Bus.iReq0_Last  = 1'b0;
    forever begin
      @(negedge Clock);
      fire0 = Bus.iReq0_Valid && Bus.oReq0_Ready;
      @(posedge Clock);
      #1;
      if (fire0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        Bus.iReq0_Valid = 1'b1;
        {Bus.iReq0_Last, Bus.iReq0_Data} = q0[0];
      end else begin
        Bus.iReq0_Valid = 1'b0;
      end
    end
  end

  // Requester 1 feeder
  initial begin
    Bus.iReq1_Valid = 1'b0;
    Bus.iReq1_Data  = 8'h00;
    Bus.iReq1_Last  = 1'b0;
    forever begin
      @(negedge Clock);
      fire1 = Bus.iReq1_Valid && Bus.oReq1_Ready;
      @(posedge Clock);
      #1;
      if (fire1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        Bus.iReq1_Valid = 1'b1;
        {Bus.iReq1_Last, Bus.iReq1_Data} = q1[0];
      end else begin
        Bus.iReq1_Valid = 1'b0;
      end
    end
  end

  // Behavioural LCD driver
  initial begin
    Bus.iLCD_Ready       = 1'b0;
    Bus.iLCD_Initialized = 1'b0;
    forever begin
      @(negedge Clock);
      if (Bus.oLCD_WriteEnable === 1'b1) begin
        obsQ.push_back({Bus.oOwner, Bus.oLCD_Data});
        wePulses++;
        if (drvMode == DRV_NORMAL) begin
          busyLen = $urandom_range(2, 40);
          @(posedge Clock);
          #1 Bus.iLCD_Ready = 1'b0;
          repeat (busyLen) @(posedge Clock);
          #1 Bus.iLCD_Ready = 1'b1;
        end else if (drvMode == DRV_HANG) begin
          @(posedge Clock);
          #1 Bus.iLCD_Ready = 1'b0;
        end
      end
    end
  end

  // Safety net: all waits are bounded, this only guards against a bench bug.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick(int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    Reset                = 1'b1;
    drvMode              = DRV_NORMAL;
    Bus.iLCD_Initialized = 1'b0;
    Bus.iLCD_Ready       = 1'b0;
    q0.delete();
    q1.delete();
    tick(3);
    obsQ.delete();
    wePulses = 0;
    Reset    = 1'b0;
  endtask

  task automatic bringUp();
    Bus.iLCD_Initialized = 1'b1;
    Bus.iLCD_Ready       = 1'b1;
  endtask

  task automatic waitBytes(string tag, int n, int maxCyc);
    int c = 0;
    while (obsQ.size() < n && c < maxCyc) begin
      tick(1);
      c++;
    end
    check(tag, obsQ.size(), n);
  endtask

  task automatic waitIdle(string tag, int maxCyc);
    int c = 0;
    while ((Bus.oBusy !== 1'b0 || q0.size() != 0 || q1.size() != 0) && c < maxCyc) begin
      tick(1);
      c++;
    end
    check(tag, Bus.oBusy, 0);
  endtask

  function automatic logic [31:0] allOutputs();
    return {Bus.oReq0_Ready, Bus.oReq1_Ready, Bus.oLCD_WriteEnable, Bus.oLCD_Data,
            Bus.oOwner, Bus.oBusy, Bus.oError, Bus.oByteCount};
  endfunction

  initial begin
    logic        sawReady;
    logic [8:0]  exp[$];
    logic [8:0]  m0[$];
    logic [8:0]  m1[$];
    logic [8:0]  b;
    logic [7:0]  d;
    logic        prio;
    logic        sender;
    int          total;
    int          lat;

    // ---------------- reset state ----------------
    doReset();
    check("reset_outputs", allOutputs(), 0);

    // ---------------- init gating ----------------
    q0.push_back({1'b1, 8'h41});
    Bus.iLCD_Ready = 1'b1;
    sawReady = 1'b0;
    repeat (100) begin
      tick(1);
      if (Bus.oReq0_Ready !== 1'b0) sawReady = 1'b1;
    end
    check("init_no_ready", sawReady, 0);
    check("init_no_we", wePulses, 0);
    Bus.iLCD_Initialized = 1'b1;
    tick(1);
    check("init_arb_ready", Bus.oReq0_Ready, 1);
    check("init_arb_no_we", Bus.oLCD_WriteEnable, 0);
    tick(1);
    check("init_we", Bus.oLCD_WriteEnable, 1);
    check("init_data", Bus.oLCD_Data, 8'h41);
    waitIdle("init_idle", 200);
    check("init_pulses", wePulses, 1);
    check("init_count", Bus.oByteCount, 1);

    // ---------------- packet lock (priority now with requester 1) ----------------
    obsQ.delete();
    q0.push_back({1'b1, 8'h58});
    q1.push_back({1'b0, 8'h4F});
    q1.push_back({1'b0, 8'h4B});
    q1.push_back({1'b1, 8'h0A});
    waitBytes("lock_bytes", 4, 600);
    waitIdle("lock_idle", 200);
    exp = '{{1'b1, 8'h4F}, {1'b1, 8'h4B}, {1'b1, 8'h0A}, {1'b0, 8'h58}};
    for (int i = 0; i < 4; i++) check($sformatf("lock_byte%0d", i), obsQ[i], exp[i]);
    check("lock_count", Bus.oByteCount, 5);

    // ---------------- round-robin ----------------
    doReset();
    bringUp();
    q0.push_back({1'b1, 8'h30});
    q0.push_back({1'b1, 8'h30});
    q1.push_back({1'b1, 8'h31});
    q1.push_back({1'b1, 8'h31});
    waitBytes("rr_bytes", 4, 600);
    waitIdle("rr_idle", 200);
    exp = '{{1'b0, 8'h30}, {1'b1, 8'h31}, {1'b0, 8'h30}, {1'b1, 8'h31}};
    for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), obsQ[i], exp[i]);
    check("rr_count", Bus.oByteCount, 4);

    // ---------------- randomized packets vs reference model ----------------
    doReset();
    bringUp();
    for (int r = 0; r < 2; r++) begin
      int nPk = $urandom_range(3, 5);
      for (int p = 0; p < nPk; p++) begin
        int len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom);
          b = {(k == len - 1) ? 1'b1 : 1'b0, d};
          if (r == 0) q0.push_back(b);
          else        q1.push_back(b);
        end
      end
    end
    m0 = q0;
    m1 = q1;
    total = m0.size() + m1.size();
    exp.delete();
    prio = 1'b0;
    // Whole packets go out one at a time; the next turn goes to the other
    // requester when it has data.
    while (m0.size() > 0 || m1.size() > 0) begin
      if (prio) sender = (m1.size() > 0) ? 1'b1 : 1'b0;
      else      sender = (m0.size() > 0) ? 1'b0 : 1'b1;
      do begin
        b = sender ? m1.pop_front() : m0.pop_front();
        exp.push_back({sender, b[7:0]});
      end while (!b[8]);
      prio = !sender;
    end
    waitBytes("rand_bytes", total, total * 60 + 100);
    waitIdle("rand_idle", 200);
    for (int i = 0; i < total; i++) check($sformatf("rand_byte%0d", i), obsQ[i], exp[i]);
    check("rand_count", Bus.oByteCount, total);

    // ---------------- busy watchdog ----------------
    doReset();
    bringUp();
    drvMode = DRV_IGNORE;
    q0.push_back({1'b1, 8'h21});
    waitBytes("bwd_pulse", 1, 50);
    lat = 0;
    while (Bus.oError !== 1'b1 && lat < 4) begin
      tick(1);
      lat++;
    end
    check("bwd_error", Bus.oError, 1);
    check("bwd_arb", Bus.oBusy, 0);
    check("bwd_count", Bus.oByteCount, 0);
    tick(5);
    check("bwd_no_reissue", wePulses, 1);
    check("bwd_sticky", Bus.oError, 1);

    // ---------------- done watchdog + lock release ----------------
    doReset();
    bringUp();
    drvMode = DRV_HANG;
    q1.push_back({1'b0, 8'h77});
    waitBytes("dwd_pulse", 1, 50);
    tick(64);
    check("dwd_before", {Bus.oError, Bus.oBusy}, 2'b01);
    tick(1);
    check("dwd_after", {Bus.oError, Bus.oBusy}, 2'b10);
    check("dwd_count", Bus.oByteCount, 0);
    drvMode = DRV_NORMAL;
    q0.push_back({1'b1, 8'h55});
    Bus.iLCD_Ready = 1'b1;
    waitBytes("dwd_unlock", 2, 200);
    check("dwd_other_req", obsQ[1], {1'b0, 8'h55});
    waitIdle("dwd_idle", 200);
    check("dwd_count2", Bus.oByteCount, 1);

    // ---------------- reset mid-write ----------------
    doReset();
    bringUp();
    q0.push_back({1'b1, 8'h12});
    waitBytes("rst_first", 1, 50);
    waitIdle("rst_first_idle", 200);
    drvMode = DRV_HANG;
    q1.push_back({1'b0, 8'h34});
    waitBytes("rst_second", 2, 50);
    tick(5);
    check("rst_in_done", {Bus.oBusy, Bus.oByteCount}, {1'b1, 16'd1});
    Reset = 1'b1;
    tick(1);
    check("rst_outputs", allOutputs(), 0);
    tick(4);
    check("rst_no_we", wePulses, 2);
    doReset();

    // ---------------- byte counter wrap ----------------
    bringUp();
    force dut.byteCount = 16'hFFFF;
    tick(1);
    release dut.byteCount;
    tick(1);
    check("wrap_preload", Bus.oByteCount, 16'hFFFF);
    q0.push_back({1'b1, 8'h5A});
    waitBytes("wrap_write", 1, 50);
    waitIdle("wrap_idle", 200);
    check("wrap_count", Bus.oByteCount, 16'h0000);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
